anton_neopixel_apb_master: RTL
==============================

Name: anton_neopixel_apb_master

Overview:
APB initiator that streams pixel bytes into the neopixel APB slave, the responder side of the same bus. Accepts a byte stream with valid/ready/last framing and issues one APB write per byte. Byte index i is written at word-aligned address i<<2. Sits between a pattern/DMA source and the neopixel peripheral in the apbPclk domain.

Parameters:
PIXELS_MAX, 66, number of byte slots addressable in the slave; the index range is 0..PIXELS_MAX-1.
PIXELS_BITS, `CLOG2(PIXELS_MAX), localparam; index width.
TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles to wait for apbPready before aborting.

Ports:
apbPclk  in  1  bus clock; all logic is on its rising edge.
apbPresern  in  1  asynchronous active-low reset.
streamData  in  8  pixel byte.
streamValid  in  1  streamData is valid.
streamLast  in  1  final byte of a frame; qualified by streamValid.
streamReady  out  1  byte accepted when streamValid && streamReady.
apbPselx  out  1  slave select.
apbPenable  out  1  access phase.
apbPwrite  out  1  write (1) or read (0).
apbPaddr  out  PIXELS_BITS+2  byte address, with bits [1:0] always 0.
apbPwData  out  8  write data.
apbPrData  in  8  read data.
apbPready  in  1  slave ready.
apbPslverr  in  1  slave error, sampled with apbPready.
busy  out  1  state is not IDLE.
frameDone  out  1  single-cycle pulse when the last byte of a frame completes.
overflow  out  1  sticky flag: the index wrapped without streamLast.
errCount  out  8  saturating count of transfers with slverr, timeout or mismatch.
errClear  in  1  synchronous clear of errCount and overflow.

Behaviour:
- Reset (async, apbPresern=0): state IDLE; all outputs 0; index=0; held byte=0; held last flag=0.
- FSM states: IDLE, SETUP, ACCESS, plus RSETUP and RACCESS when the optional feature is compiled in.
- IDLE: streamReady=1. On a handshake, latch the byte and last flag, then go to SETUP.
- SETUP, one cycle: apbPselx=1, apbPenable=0, apbPwrite=1, apbPaddr={index,2'b00}, apbPwData=held byte. Go to ACCESS.
- ACCESS: apbPselx=1, apbPenable=1, and address and data are held stable. A wait counter starts at 0 on ACCESS entry.
  - apbPready=1: the transfer completes; go to the completion step.
  - apbPready=0: increment the counter. If the counter reaches TIMEOUT_CYCLES-1 with apbPready still 0, abort and treat the transfer as an error.
- Completion step:
  - Increment errCount (saturating at 255) if apbPslverr=1 or the transfer timed out.
  - If the held last flag is set: index=0 and frameDone=1 for that cycle.
  - Else if index==PIXELS_MAX-1: index=0 and overflow=1.
  - Otherwise index=index+1.
  - Return to IDLE, with apbPselx and apbPenable low next cycle.
- Minimum latency per byte: 3 cycles (IDLE, SETUP, ACCESS). streamReady is 0 in every state other than IDLE.
- A bus error does not stop the frame; index still advances.
- errClear and an error increment in the same cycle: the clear wins.
- Reset mid-transfer: the bus is released immediately (apbPselx=0) and the partial byte is discarded.
- apbPaddr and apbPwData read as 0 while apbPselx=0.

Optional Feature:
ANTON_NEOPIXEL_MASTER_VERIFY_EN
- When defined: after a successful write (no slverr, no timeout), run RSETUP then RACCESS.
  - Both read phases use the same address with apbPwrite=0 and the same timeout rule.
  - On read completion, compare apbPrData with the held byte; a mismatch, slverr or timeout increments errCount.
  - The index update and frameDone are deferred until the read completes.
  - Minimum latency becomes 5 cycles per byte.
- When undefined: the read states are absent and apbPwrite is constantly 1 whenever apbPselx=1.

Test Plan:
- Reset with the slave holding apbPready=1; stream 0x11, 0x22, 0x33 with last on 0x33 -> writes at apbPaddr 0x000, 0x004, 0x008; frameDone pulses once; index returns to 0; errCount=0.
- Slave inserts 3 wait cycles per transfer; stream one byte 0xA5 -> apbPaddr, apbPwData and apbPselx held stable for 4 ACCESS cycles; streamReady stays 0 throughout.
- Slave never asserts apbPready -> abort after 16 ACCESS cycles; errCount=1; next byte goes to apbPaddr 0x004.
- Stream 67 bytes with no last -> byte 66 written at 0x104; byte 67 written at 0x000; overflow=1; then errClear -> overflow=0 and errCount=0.
- apbPslverr=1 on the second byte -> errCount=1 and the frame continues; with VERIFY_EN and the slave returning 0x00 for a written 0x5A -> errCount increments and a read at the same address with apbPwrite=0 is observed.
- Assert apbPresern low during ACCESS -> apbPselx and apbPenable drop asynchronously; after release the state is IDLE and streamReady=1.

Source files
------------

// File: rtl/anton_neopixel_apb_master.sv
// rtl/anton_neopixel_apb_master.sv - byte stream to APB write initiator for the neopixel slave
// Optional read-back compare of every written byte: define ANTON_NEOPIXEL_MASTER_VERIFY_EN.
module anton_neopixel_apb_master #(
    parameter int  PIXELS_MAX     = 66,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int PIXELS_BITS    = $clog2(PIXELS_MAX)
) (
    input  logic                   apbPclk,
    input  logic                   apbPresern,
    input  logic [7:0]             streamData,
    input  logic                   streamValid,
    input  logic                   streamLast,
    output logic                   streamReady,
    output logic                   apbPselx,
    output logic                   apbPenable,
    output logic                   apbPwrite,
    output logic [PIXELS_BITS+1:0] apbPaddr,
    output logic [7:0]             apbPwData,
    input  logic [7:0]             apbPrData,
    input  logic                   apbPready,
    input  logic                   apbPslverr,
    output logic                   busy,
    output logic                   frameDone,
    output logic                   overflow,
    output logic [7:0]             errCount,
    input  logic                   errClear
);
    localparam int                     WAIT_BITS  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_BITS-1:0]   WAIT_LAST  = WAIT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [PIXELS_BITS-1:0] INDEX_LAST = PIXELS_BITS'(PIXELS_MAX - 1);

`ifdef ANTON_NEOPIXEL_MASTER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_RSETUP, S_RACCESS} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
`endif

    state_t                 state_q;
    logic [PIXELS_BITS-1:0] index_q, index_d;
    logic [7:0]             byte_q;
    logic                   last_q;
    logic [WAIT_BITS-1:0]   wait_q;
    logic                   ready_q, busy_q, psel_q, penable_q, pwrite_q, frame_done_q;
    logic                   overflow_q, overflow_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic                   timeout_hit, xfer_end, xfer_err;
`ifdef ANTON_NEOPIXEL_MASTER_VERIFY_EN
    logic                   start_read;
`else
    logic                   unused_prdata;
    assign unused_prdata = ^apbPrData;
`endif

    // xfer_end marks the cycle a byte is finished (write, or read-back when verifying)
    always_comb begin
        timeout_hit = !apbPready && (wait_q == WAIT_LAST);
        xfer_end    = 1'b0;
        xfer_err    = 1'b0;
`ifdef ANTON_NEOPIXEL_MASTER_VERIFY_EN
        start_read  = 1'b0;
        if (state_q == S_ACCESS && (apbPready || timeout_hit)) begin
            start_read = !(timeout_hit || apbPslverr);
            xfer_end   = !start_read;
            xfer_err   = !start_read;
        end
        if (state_q == S_RACCESS && (apbPready || timeout_hit)) begin
            xfer_end = 1'b1;
            xfer_err = timeout_hit || apbPslverr || (apbPrData != byte_q);
        end
`else
        if (state_q == S_ACCESS && (apbPready || timeout_hit)) begin
            xfer_end = 1'b1;
            xfer_err = timeout_hit || apbPslverr;
        end
`endif
    end

    always_comb begin
        index_d    = index_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;
        if (xfer_end) begin
            if (last_q) begin
                index_d = '0;
            end else if (index_q == INDEX_LAST) begin
                index_d    = '0;
                overflow_d = 1'b1;
            end else begin
                index_d = index_q + 1'b1;
            end
            if (xfer_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
        end
        if (errClear) begin
            err_cnt_d  = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge apbPclk or negedge apbPresern) begin
        if (!apbPresern) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            byte_q       <= '0;
            last_q       <= 1'b0;
            wait_q       <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            index_q      <= index_d;
            overflow_q   <= overflow_d;
            err_cnt_q    <= err_cnt_d;
            frame_done_q <= 1'b0;
            if (xfer_end) begin
                state_q      <= S_IDLE;
                psel_q       <= 1'b0;
                penable_q    <= 1'b0;
                pwrite_q     <= 1'b0;
                busy_q       <= 1'b0;
                ready_q      <= 1'b1;
                frame_done_q <= last_q;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        ready_q <= 1'b1;
                        if (streamValid && ready_q) begin
                            byte_q   <= streamData;
                            last_q   <= streamLast;
                            ready_q  <= 1'b0;
                            busy_q   <= 1'b1;
                            psel_q   <= 1'b1;
                            pwrite_q <= 1'b1;
                            state_q  <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        penable_q <= 1'b1;
                        wait_q    <= '0;
                        state_q   <= S_ACCESS;
                    end
                    S_ACCESS: begin
`ifdef ANTON_NEOPIXEL_MASTER_VERIFY_EN
                        if (start_read) begin
                            penable_q <= 1'b0;
                            pwrite_q  <= 1'b0;
                            state_q   <= S_RSETUP;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
`else
                        wait_q <= wait_q + 1'b1;
`endif
                    end
`ifdef ANTON_NEOPIXEL_MASTER_VERIFY_EN
                    S_RSETUP: begin
                        penable_q <= 1'b1;
                        wait_q    <= '0;
                        state_q   <= S_RACCESS;
                    end
                    S_RACCESS: wait_q <= wait_q + 1'b1;
`endif
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Index is only updated at completion, so address and data stay stable for the whole transfer
    assign apbPaddr    = psel_q ? {index_q, 2'b00} : '0;
    assign apbPwData   = psel_q ? byte_q : '0;
    assign apbPselx    = psel_q;
    assign apbPenable  = penable_q;
    assign apbPwrite   = pwrite_q;
    assign streamReady = ready_q;
    assign busy        = busy_q;
    assign frameDone   = frame_done_q;
    assign overflow    = overflow_q;
    assign errCount    = err_cnt_q;
endmodule
